// File: rtl/reg_file_pkg.sv
// Shared sizing for the architectural register file and its rename tags.
package reg_file_pkg;
    localparam int REG_NUM     = 32;
    localparam int REG_POS_WID = 5;
    localparam int DATA_WID    = 32;
    localparam int ROB_POS_WID = 4;
    localparam int ROB_SIZE    = 1 << ROB_POS_WID;

    typedef struct packed {
        logic                   busy;
        logic [DATA_WID-1:0]    val;
        logic [ROB_POS_WID-1:0] rob_pos;
    } query_t;

    // Source-operand lookup with same-cycle commit forwarding.
    function automatic query_t reg_query(
        input logic [REG_POS_WID-1:0] pos,
        input logic                   busy,
        input logic [DATA_WID-1:0]    val,
        input logic [ROB_POS_WID-1:0] tag,
        input logic                   wr,
        input logic [REG_POS_WID-1:0] wr_rd,
        input logic [DATA_WID-1:0]    wr_val,
        input logic [ROB_POS_WID-1:0] wr_rob_pos
    );
        query_t q;
        q.busy    = busy;
        q.val     = val;
        q.rob_pos = tag;
        if (pos == '0) begin
            q.busy = 1'b0;
            q.val  = '0;
        end else if (wr && wr_rd == pos && busy && tag == wr_rob_pos) begin
            q.busy = 1'b0;
            q.val  = wr_val;
        end
        return q;
    endfunction
endpackage

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags; commit writes
// from the ROB, issue-time tagging, and combinational decoder queries.
module reg_file
    import reg_file_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   rollback,
    input  logic                   issue,
    input  logic [REG_POS_WID-1:0] issue_rd,
    input  logic [ROB_POS_WID-1:0] issue_rob_pos,
    input  logic                   reg_write,
    input  logic [REG_POS_WID-1:0] reg_rd,
    input  logic [DATA_WID-1:0]    reg_val,
    input  logic [ROB_POS_WID-1:0] commit_rob_pos,
    input  logic [REG_POS_WID-1:0] rs1_pos,
    output logic                   rs1_busy,
    output logic [DATA_WID-1:0]    rs1_val,
    output logic [ROB_POS_WID-1:0] rs1_rob_pos,
    input  logic [REG_POS_WID-1:0] rs2_pos,
    output logic                   rs2_busy,
    output logic [DATA_WID-1:0]    rs2_val,
    output logic [ROB_POS_WID-1:0] rs2_rob_pos
);

    logic [DATA_WID-1:0]    val_q  [REG_NUM];
    logic [DATA_WID-1:0]    val_d  [REG_NUM];
    logic                   busy_q [REG_NUM];
    logic                   busy_d [REG_NUM];
    logic [ROB_POS_WID-1:0] tag_q  [REG_NUM];
    logic [ROB_POS_WID-1:0] tag_d  [REG_NUM];

    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (reg_write && reg_rd != '0) begin
            val_d[reg_rd] = reg_val;
            if (tag_q[reg_rd] == commit_rob_pos) begin
                busy_d[reg_rd] = 1'b0;
            end
        end
        // Rollback may coincide with a commit (JALR); the value write above still lands.
        if (rollback) begin
            for (int i = 0; i < REG_NUM; i++) begin
                busy_d[i] = 1'b0;
            end
        end else if (issue && issue_rd != '0) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_rob_pos;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else if (rdy) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i]  <= val_d[i];
                busy_q[i] <= busy_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    query_t rs1_q;
    query_t rs2_q;

    always_comb begin
        rs1_q = reg_query(rs1_pos, busy_q[rs1_pos], val_q[rs1_pos], tag_q[rs1_pos],
                          reg_write, reg_rd, reg_val, commit_rob_pos);
        rs2_q = reg_query(rs2_pos, busy_q[rs2_pos], val_q[rs2_pos], tag_q[rs2_pos],
                          reg_write, reg_rd, reg_val, commit_rob_pos);
    end

    assign rs1_busy    = rs1_q.busy;
    assign rs1_val     = rs1_q.val;
    assign rs1_rob_pos = rs1_q.rob_pos;
    assign rs2_busy    = rs2_q.busy;
    assign rs2_val     = rs2_q.val;
    assign rs2_rob_pos = rs2_q.rob_pos;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboarded bench for reg_file: a driver pushes model predictions, a monitor
// pops and compares them against the combinational query outputs.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, issue, reg_write;
    logic [4:0]  issue_rd, reg_rd, rs1_pos, rs2_pos;
    logic [3:0]  issue_rob_pos, commit_rob_pos;
    logic [31:0] reg_val;
    logic        rs1_busy, rs2_busy;
    logic [31:0] rs1_val, rs2_val;
    logic [3:0]  rs1_rob_pos, rs2_rob_pos;

    always #5 clk = ~clk;

    reg_file dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
        .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
        .commit_rob_pos(commit_rob_pos),
        .rs1_pos(rs1_pos), .rs1_busy(rs1_busy), .rs1_val(rs1_val), .rs1_rob_pos(rs1_rob_pos),
        .rs2_pos(rs2_pos), .rs2_busy(rs2_busy), .rs2_val(rs2_val), .rs2_rob_pos(rs2_rob_pos)
    );

    typedef struct {
        logic       rst, rdy, rb, iss;
        logic [4:0] ird;
        logic [3:0] ipos;
        logic       rw;
        logic [4:0] rrd;
        logic [31:0] rval;
        logic [3:0] cpos;
        logic [4:0] q1, q2;
    } stim_t;

    typedef struct {
        logic        busy;
        logic [31:0] val;
        logic [3:0]  rob;
    } exp_t;

    typedef struct {
        exp_t e1, e2;
    } exp_pair_t;

    // Reference state: what each architectural register holds, whether a
    // result is pending, and which ROB entry will deliver it.
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];
    bit          m_known = 0;

    exp_pair_t sb[$];
    int tests = 0;
    int fails = 0;

    function automatic exp_t predict(input logic [4:0] pos, input stim_t s);
        exp_t e;
        e.rob = m_tag[pos];
        if (pos == 0) begin
            e.busy = 0;
            e.val  = 0;
        end else if (s.rw && s.rrd == pos && m_busy[pos] && m_tag[pos] == s.cpos) begin
            e.busy = 0;
            e.val  = s.rval;
        end else begin
            e.busy = m_busy[pos];
            e.val  = m_val[pos];
        end
        return e;
    endfunction

    task automatic model_edge(input stim_t s);
        if (s.rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
            end
            m_known = 1;
        end else if (s.rdy && m_known) begin
            if (s.rw && s.rrd != 0) begin
                m_val[s.rrd] = s.rval;
                if (m_tag[s.rrd] == s.cpos) m_busy[s.rrd] = 0;
            end
            if (s.rb) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else if (s.iss && s.ird != 0) begin
                m_busy[s.ird] = 1;
                m_tag[s.ird]  = s.ipos;
            end
        end
    endtask

    // Called just after a rising edge: drive one cycle, predict, then advance.
    task automatic step(input stim_t s);
        exp_pair_t p;
        rst = s.rst; rdy = s.rdy; rollback = s.rb;
        issue = s.iss; issue_rd = s.ird; issue_rob_pos = s.ipos;
        reg_write = s.rw; reg_rd = s.rrd; reg_val = s.rval; commit_rob_pos = s.cpos;
        rs1_pos = s.q1; rs2_pos = s.q2;
        if (m_known) begin
            p.e1 = predict(s.q1, s);
            p.e2 = predict(s.q2, s);
            sb.push_back(p);
        end
        @(posedge clk);
        model_edge(s);
        #1;
    endtask

    function automatic stim_t idle(input logic [4:0] q1, input logic [4:0] q2);
        stim_t s;
        s.rst = 0; s.rdy = 1; s.rb = 0; s.iss = 0; s.ird = 0; s.ipos = 0;
        s.rw = 0; s.rrd = 0; s.rval = 0; s.cpos = 0; s.q1 = q1; s.q2 = q2;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_pair_t p;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                p = sb.pop_front();
                chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, p.e1.busy});
                chk("rs1_val", rs1_val, p.e1.val);
                chk("rs1_rob_pos", {28'b0, rs1_rob_pos}, {28'b0, p.e1.rob});
                chk("rs2_busy", {31'b0, rs2_busy}, {31'b0, p.e2.busy});
                chk("rs2_val", rs2_val, p.e2.val);
                chk("rs2_rob_pos", {28'b0, rs2_rob_pos}, {28'b0, p.e2.rob});
            end
        end
    end

    initial begin : driver
        stim_t s;
        @(posedge clk); #1;

        s = idle(0, 0); s.rst = 1; step(s);
        step(idle(5, 5));
        s = idle(5, 0); s.iss = 1; s.ird = 5; s.ipos = 3; step(s);
        s = idle(5, 0); s.iss = 1; s.ird = 5; s.ipos = 7; step(s);
        s = idle(5, 0); s.rw = 1; s.rrd = 5; s.cpos = 3; s.rval = 32'h11; step(s);
        s = idle(5, 0); s.rw = 1; s.rrd = 5; s.cpos = 7; s.rval = 32'h22; step(s);
        s = idle(5, 6); s.iss = 1; s.ird = 6; s.ipos = 2; step(s);
        s = idle(5, 6); s.rw = 1; s.rrd = 6; s.cpos = 2; s.rval = 32'hDEAD; step(s);
        s = idle(0, 6); s.iss = 1; s.ird = 0; s.ipos = 1;
        s.rw = 1; s.rrd = 0; s.rval = 32'hFFFF; s.cpos = 1; step(s);
        step(idle(0, 6));

        s = idle(3, 9); s.iss = 1; s.ird = 3; s.ipos = 4; step(s);
        s = idle(3, 9); s.iss = 1; s.ird = 9; s.ipos = 5; step(s);
        s = idle(3, 9); s.rb = 1; s.rw = 1; s.rrd = 1; s.cpos = 6; s.rval = 32'h80;
        s.iss = 1; s.ird = 3; s.ipos = 8; step(s);
        step(idle(1, 3));
        step(idle(9, 5));

        s = idle(7, 8); s.iss = 1; s.ird = 7; s.ipos = 9; step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(7, 8); s.rdy = 0;
            s.iss = i[0]; s.ird = 8; s.ipos = 4'(i);
            s.rw = ~i[0]; s.rrd = 7; s.cpos = 9; s.rval = 32'hA5A5_0000 + i;
            step(s);
        end
        step(idle(7, 8));
        s = idle(7, 5); s.rst = 1; step(s);
        step(idle(7, 5));

        for (int n = 0; n < 600; n++) begin
            s = idle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            s.rst  = ($urandom_range(0, 99) == 0);
            s.rdy  = ($urandom_range(0, 9) != 0);
            s.rb   = ($urandom_range(0, 29) == 0);
            s.iss  = ($urandom_range(0, 1) == 0);
            s.ird  = 5'($urandom_range(0, 7));
            s.ipos = 4'($urandom);
            s.rw   = ($urandom_range(0, 1) == 0);
            s.rrd  = 5'($urandom_range(0, 7));
            s.rval = $urandom;
            s.cpos = ($urandom_range(0, 1) == 0) ? m_tag[s.rrd] : 4'($urandom);
            if ($urandom_range(0, 2) == 0) s.q1 = s.rrd;
            if ($urandom_range(0, 2) == 0) s.q2 = s.ird;
            step(s);
        end

        step(idle(0, 0));
        repeat (2) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
